wb_cmd_master: RTL

Wishbone pipelined-mode initiator (bus master) that turns single register-access commands from a local valid/ready command port into one Wishbone transaction each, and returns the read data or termination status on a valid/ready response port. It drives the generated register-bank slaves (sreg-style banks) from control logic or a host bridge. It keeps one transaction outstanding, retries on `rty`, and aborts hung cycles with a timeout.

---
 rtl/wb_cmd_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined-mode initiator: one register-access command in, one bus
// transaction out, one response back. Retries on rty, aborts hung cycles on timeout.
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_tmo_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i,
  output logic [1:0]            dbg_state_o
);

  // Both ports: a transfer happens on a clock edge where valid and ready are
  // both high; valid, once raised, holds its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RSP = 2'd3} state_e;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

  state_e                  state_q, state_d;
  logic                    retry_pend_q, retry_pend_d;
  logic [3:0]              retry_cnt_q, retry_cnt_d;
  logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [3:0]              sel_q, sel_d;
  logic [31:0]             dat_q, dat_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_tmo_q, rsp_tmo_d;
  logic [31:0]             rsp_dat_q, rsp_dat_d;
  logic                    tmo_hit;

  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LIMIT);

  always_comb begin
    state_d      = state_q;
    retry_pend_d = retry_pend_q;
    retry_cnt_d  = retry_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_err_d    = rsp_err_q;
    rsp_tmo_d    = rsp_tmo_q;
    case (state_q)
      IDLE: begin
        // A pending retry re-issues the held request after one cycle with cyc low.
        if (retry_pend_q) begin
          retry_pend_d = 1'b0;
          tmo_cnt_d    = '0;
          state_d      = REQ;
        end else if (cmd_valid_i && cmd_ready_q) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          sel_d       = cmd_sel_i;
          dat_d       = cmd_dat_i;
          retry_cnt_d = '0;
          tmo_cnt_d   = '0;
          state_d     = REQ;
        end
      end
      REQ, WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (wb_err_i) begin
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = RSP;
        end else if (wb_rty_i) begin
          if (retry_cnt_q < RETRY_LIMIT) begin
            retry_cnt_d  = retry_cnt_q + 4'd1;
            retry_pend_d = 1'b1;
            state_d      = IDLE;
          end else begin
            rsp_err_d = 1'b1;
            rsp_dat_d = '0;
            state_d   = RSP;
          end
        end else if (wb_ack_i) begin
          rsp_dat_d = we_q ? 32'd0 : wb_dat_i;
          state_d   = RSP;
        end else if (tmo_hit) begin
          rsp_tmo_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = RSP;
        end else if (state_q == REQ && !wb_stall_i) begin
          state_d = WAIT;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_err_d = 1'b0;
          rsp_tmo_d = 1'b0;
          rsp_dat_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered decodes of the next state.
    cyc_d       = (state_d == REQ) || (state_d == WAIT);
    stb_d       = (state_d == REQ);
    rsp_valid_d = (state_d == RSP);
    cmd_ready_d = (state_d == IDLE) && !retry_pend_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      retry_pend_q <= 1'b0;
      retry_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      cmd_ready_q  <= 1'b1;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      retry_pend_q <= retry_pend_d;
      retry_cnt_q  <= retry_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tmo_q    <= rsp_tmo_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;
  assign dbg_state_o = state_q;

endmodule
